// File: rtl/uart_seq_pkg.sv
// Shared types and byte constants for the UART/RAM command sequencer.
// State codes double as the LED indicator value, so the encoding is fixed.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_LEN  = 3'd2,
    WR_DATA  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_WAIT  = 3'd5,
    RD_SEND  = 3'd6,
    RESP     = 3'd7
  } state_t;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // States in which the sequencer is listening to the host.
  function automatic logic is_rx_state(input state_t s);
    return (s == IDLE) || (s == GET_ADDR) || (s == GET_LEN) || (s == WR_DATA);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Inter-byte idle watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT_CYC-th idle cycle.
module seq_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  assign expired = enable && (count >= LAST);

  // Holds at the limit rather than wrapping, so a stalled FSM cannot miss expiry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_mem_sequencer.sv
// Host command sequencer between the byte UART and the single-port RAM:
// OP, ADDR, LEN (0 = 256), then LEN data bytes for writes; reads stream back LEN bytes.
module uart_mem_sequencer
  import uart_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic [7:0]        err_cnt,
  output logic [2:0]        state_o
);

  state_t            state;
  logic              is_wr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [8:0]        len;
  logic              rx_fire;
  logic              tx_fire;
  logic              tmo_en;
  logic              tmo_expired;

  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign addr_next = addr + ADDR_W'(1);
  assign tmo_en    = (state == GET_ADDR) || (state == GET_LEN) || (state == WR_DATA);
  assign busy      = (state != IDLE);
  assign state_o   = state;

  seq_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (rx_fire),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  // rx_ready follows the state it is entering, so it is dropped on the same edge
  // that raises tx_valid and never overlaps with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      addr      <= '0;
      len       <= '0;
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      mem_din   <= '0;
      err_cnt   <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      rx_ready  <= is_rx_state(state);
      if (tmo_expired && !rx_fire) begin
        state   <= IDLE;
        err_cnt <= sat_inc(err_cnt);
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_fire) begin
              if (rx_data == DATA_W'(OP_WR) || rx_data == DATA_W'(OP_RD)) begin
                is_wr <= (rx_data == DATA_W'(OP_WR));
                state <= GET_ADDR;
              end else begin
                tx_data  <= DATA_W'(NAK);
                tx_valid <= 1'b1;
                rx_ready <= 1'b0;
                err_cnt  <= sat_inc(err_cnt);
                state    <= RESP;
              end
            end
          end
          GET_ADDR: begin
            if (rx_fire) begin
              addr  <= ADDR_W'(rx_data);
              state <= GET_LEN;
            end
          end
          GET_LEN: begin
            if (rx_fire) begin
              len <= (rx_data == '0) ? 9'd256 : 9'(rx_data);
              if (is_wr) begin
                state <= WR_DATA;
              end else begin
                mem_addr <= addr;
                rx_ready <= 1'b0;
                state    <= RD_ISSUE;
              end
            end
          end
          WR_DATA: begin
            if (rx_fire) begin
              mem_wr_en <= 1'b1;
              mem_addr  <= addr;
              mem_din   <= rx_data;
              addr      <= addr_next;
              len       <= len - 9'd1;
              if (len == 9'd1) begin
                tx_data  <= DATA_W'(ACK);
                tx_valid <= 1'b1;
                rx_ready <= 1'b0;
                state    <= RESP;
              end
            end
          end
          RD_ISSUE: begin
            mem_addr <= addr;
            state    <= RD_WAIT;
          end
          RD_WAIT: begin
            tx_data  <= mem_dout;
            tx_valid <= 1'b1;
            state    <= RD_SEND;
          end
          RD_SEND: begin
            if (tx_fire) begin
              tx_valid <= 1'b0;
              addr     <= addr_next;
              len      <= len - 9'd1;
              if (len == 9'd1) begin
                rx_ready <= 1'b1;
                state    <= IDLE;
              end else begin
                mem_addr <= addr_next;
                state    <= RD_ISSUE;
              end
            end
          end
          RESP: begin
            if (tx_fire) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Directed bench for uart_mem_sequencer: command vector table plus hand-written
// sequences for latency, backpressure, timeout, async reset, 256-byte and saturation.
module tb_uart_mem_sequencer;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy;
  logic [7:0] err_cnt;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  uart_mem_sequencer #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .mem_addr (mem_addr),
    .mem_wr_en(mem_wr_en),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy),
    .err_cnt  (err_cnt),
    .state_o  (state_o)
  );

  // Synchronous RAM: read data appears one cycle after the address.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  logic [7:0] txq[$];
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int viol = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (mem_wr_en) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_din);
      end
      if (tx_valid && rx_ready) viol++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 200);
    if (!rx_ready) checkOutput("rx_accept_wait_expired", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < limit);
    if (busy) checkOutput("idle_wait_expired", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    txq.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Command bytes and expected tx bytes are left-aligned, first byte in the top bits.
  typedef struct packed {
    logic [3:0]  n_bytes;
    logic [63:0] cmd;
    logic [2:0]  n_tx;
    logic [31:0] tx;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_watchdog: got expired expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       t;
    int         exp_wr;
    int         n;
    int         bad;
    logic [7:0] ea;

    vecs[0] = '{4'd6, 64'h5710_03AA_BBCC_0000, 3'd1, 32'h0600_0000, 8'd0};
    vecs[1] = '{4'd3, 64'h5210_0300_0000_0000, 3'd3, 32'hAABB_CC00, 8'd0};
    vecs[2] = '{4'd5, 64'h57FF_0211_2200_0000, 3'd1, 32'h0600_0000, 8'd0};
    vecs[3] = '{4'd3, 64'h52FF_0200_0000_0000, 3'd2, 32'h1122_0000, 8'd0};
    vecs[4] = '{4'd1, 64'h4100_0000_0000_0000, 3'd1, 32'h1500_0000, 8'd1};
    vecs[5] = '{4'd1, 64'h0000_0000_0000_0000, 3'd1, 32'h1500_0000, 8'd2};
    vecs[6] = '{4'd3, 64'h5211_0100_0000_0000, 3'd1, 32'hBB00_0000, 8'd2};

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
      {rx_ready, tx_valid, tx_data, mem_addr, mem_wr_en, mem_din, busy, err_cnt, state_o}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_after_reset", {rx_ready, busy, state_o}, {1'b1, 1'b0, 3'd0});
    @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      t = vecs[v];
      clearLogs();
      for (int i = 0; i < int'(t.n_bytes); i++) applyStimulus(t.cmd[63-8*i -: 8]);
      waitIdle(100);
      exp_wr = (t.cmd[63:56] == 8'h57) ? int'(t.cmd[47:40]) : 0;
      checkOutput($sformatf("v%0d_tx_count", v), txq.size(), t.n_tx);
      for (int i = 0; i < int'(t.n_tx) && i < txq.size(); i++)
        checkOutput($sformatf("v%0d_tx%0d", v, i), txq[i], t.tx[31-8*i -: 8]);
      checkOutput($sformatf("v%0d_wr_count", v), wr_addr_q.size(), exp_wr);
      for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
        ea = 8'(t.cmd[55:48] + 8'(i));
        checkOutput($sformatf("v%0d_wr%0d", v, i), {wr_addr_q[i], wr_data_q[i]},
                    {ea, t.cmd[39-8*i -: 8]});
      end
      checkOutput($sformatf("v%0d_err_cnt", v), err_cnt, t.err);
      checkOutput($sformatf("v%0d_idle", v), {busy, state_o}, {1'b0, 3'd0});
    end

    clearLogs();
    applyStimulus(8'h57);
    applyStimulus(8'h30);
    applyStimulus(8'h01);
    applyStimulus(8'h5C);
    checkOutput("wr_strobe_latency", {mem_wr_en, mem_addr, mem_din}, {1'b1, 8'h30, 8'h5C});
    waitIdle(50);
    checkOutput("wr_single_strobe", wr_addr_q.size(), 1);

    clearLogs();
    tx_ready = 1'b0;
    applyStimulus(8'h52);
    applyStimulus(8'h30);
    applyStimulus(8'h01);
    @(negedge clk);
    checkOutput("rd_latency_c1", {tx_valid, state_o}, {1'b0, 3'd4});
    @(negedge clk);
    checkOutput("rd_latency_c2", {tx_valid, state_o}, {1'b0, 3'd5});
    @(negedge clk);
    checkOutput("rd_latency_c3", {tx_valid, tx_data}, {1'b1, 8'h5C});
    @(posedge clk);
    #1;
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rd_backpressure_hold", {tx_valid, tx_data, rx_ready, state_o},
                {1'b1, 8'h5C, 1'b0, 3'd6});
    checkOutput("rd_rx_ignored_err", err_cnt, 8'd2);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    waitIdle(50);
    checkOutput("rd_backpressure_count", txq.size(), 1);
    if (txq.size() > 0) checkOutput("rd_backpressure_data", txq[0], 8'h5C);

    clearLogs();
    applyStimulus(8'h57);
    applyStimulus(8'h20);
    repeat (TMO - 10) @(negedge clk);
    checkOutput("tmo_before", {busy, state_o, err_cnt}, {1'b1, 3'd2, 8'd2});
    repeat (15) @(negedge clk);
    checkOutput("tmo_after", {busy, state_o, err_cnt}, {1'b0, 3'd0, 8'd3});
    checkOutput("tmo_no_activity", txq.size() + wr_addr_q.size(), 0);
    @(posedge clk);
    #1;
    applyStimulus(8'h52);
    applyStimulus(8'h20);
    applyStimulus(8'h01);
    waitIdle(50);
    checkOutput("tmo_next_cmd", {32'(txq.size()), err_cnt}, {32'd1, 8'd3});

    clearLogs();
    tx_ready = 1'b0;
    applyStimulus(8'h52);
    applyStimulus(8'h10);
    applyStimulus(8'h01);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 10);
    checkOutput("pre_reset_tx_valid", tx_valid, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
      {rx_ready, tx_valid, tx_data, mem_addr, mem_wr_en, mem_din, busy, err_cnt, state_o}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tx_ready = 1'b1;
    clearLogs();
    applyStimulus(8'h52);
    applyStimulus(8'h10);
    applyStimulus(8'h01);
    waitIdle(50);
    checkOutput("post_reset_count", txq.size(), 1);
    if (txq.size() > 0) checkOutput("post_reset_data", txq[0], 8'hAA);

    clearLogs();
    applyStimulus(8'h57);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    for (int i = 0; i < 256; i++) applyStimulus(8'(i * 7 + 3));
    waitIdle(50);
    checkOutput("wr256_count", wr_addr_q.size(), 256);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != 8'(i) || wr_data_q[i] != 8'(i * 7 + 3)) bad++;
    checkOutput("wr256_contents_bad", bad, 0);
    checkOutput("wr256_ack", {32'(txq.size()), (txq.size() > 0) ? txq[0] : 8'h00}, {32'd1, 8'h06});

    clearLogs();
    applyStimulus(8'h52);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    waitIdle(2000);
    checkOutput("rd256_count", txq.size(), 256);
    bad = 0;
    for (int i = 0; i < txq.size(); i++)
      if (txq[i] != 8'(i * 7 + 3)) bad++;
    checkOutput("rd256_data_bad", bad, 0);
    checkOutput("rd256_no_writes", wr_addr_q.size(), 0);

    for (int i = 0; i < 254; i++) begin
      applyStimulus(8'h41);
      waitIdle(20);
    end
    checkOutput("err_cnt_fe", err_cnt, 8'hFE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h41);
      waitIdle(20);
    end
    checkOutput("err_cnt_saturated", err_cnt, 8'hFF);

    checkOutput("rx_ready_with_tx_valid", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
